// File: rtl/sp_unit_mmr_cmd.sv
// MMR command unit: one-hot LOAD/STORE/SET/CLR/INTR/WAIT commands against an RW and an RO
// register bank, with results returned through the wb_done/wb_ack writeback handshake.
module sp_unit_mmr_cmd #(
    parameter int unsigned NRW        = 8,
    parameter int unsigned NRO        = 8,
    parameter int unsigned NINTR      = 4,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned RO_SEL_BIT = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  issue_new_request,
    output logic                                  issue_ready,
    input  logic [5:0]                            issue_cmd,
    input  logic [31:0]                           rs1,
    input  logic [31:0]                           rs2,
    output logic                                  wb_done,
    input  logic                                  wb_ack,
    output logic [31:0]                           result,
    input  logic [NRW*32-1:0]                     rw_data,
    input  logic [NRO*32-1:0]                     ro_data,
    output logic                                  rw_store,
    output logic [$clog2(NRW > 1 ? NRW : 2)-1:0]  rw_store_idx,
    output logic [31:0]                           rw_store_data,
    output logic [31:0]                           rw_store_mask,
    output logic [NINTR-1:0]                      isr_pulses
);

    localparam int unsigned IW = $clog2(NRW > 1 ? NRW : 2);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q;
    logic [15:0]   idx_q;
    logic          ro_q;
    logic [31:0]   mask_q;
    logic [CW-1:0] count_q;

    logic [15:0]   sel_idx;
    logic          sel_ro;
    logic [31:0]   sel_val;
    logic          sel_valid;
    logic          intr_valid;
    logic          wait_match;
    logic          accept;

    // rs1 upper bits other than the bank select carry no meaning here.
    logic unused_rs1;
    assign unused_rs1 = ^rs1;

    assign issue_ready = (state_q == StIdle);
    assign wb_done     = (state_q == StDone);
    assign accept      = issue_new_request & issue_ready;

    // The bank/index come straight from rs1 while idle and from the latched copy while polling.
    always_comb begin
        sel_idx = (state_q == StIdle) ? rs1[15:0] : idx_q;
        sel_ro  = (state_q == StIdle) ? rs1[RO_SEL_BIT] : ro_q;
        sel_val = '0;
        for (int i = 0; i < NRW; i++) begin
            if (!sel_ro && sel_idx == 16'(i)) sel_val = rw_data[32*i +: 32];
        end
        for (int i = 0; i < NRO; i++) begin
            if (sel_ro && sel_idx == 16'(i)) sel_val = ro_data[32*i +: 32];
        end
        sel_valid  = sel_ro ? (32'(sel_idx) < NRO) : (32'(sel_idx) < NRW);
        intr_valid = 32'(rs1[15:0]) < NINTR;
        wait_match = (sel_val & mask_q) == mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            ro_q          <= 1'b0;
            mask_q        <= '0;
            count_q       <= '0;
            result        <= '0;
            rw_store      <= 1'b0;
            rw_store_idx  <= '0;
            rw_store_data <= '0;
            rw_store_mask <= '0;
            isr_pulses    <= '0;
        end else begin
            rw_store   <= 1'b0;
            isr_pulses <= '0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        idx_q   <= rs1[15:0];
                        ro_q    <= rs1[RO_SEL_BIT];
                        mask_q  <= rs2;
                        count_q <= '0;
                        state_q <= StDone;
                        if (issue_cmd[5]) begin
                            if (sel_valid) state_q <= StWait;
                            else           result  <= 32'h8000_0000;
                        end else if (issue_cmd[0]) begin
                            result <= sel_valid ? sel_val : 32'h0;
                        end else if (issue_cmd[1] || issue_cmd[2] || issue_cmd[3]) begin
                            // Stores into the RO bank or out of range are dropped and flagged.
                            if (sel_valid && !sel_ro) begin
                                rw_store      <= 1'b1;
                                rw_store_idx  <= sel_idx[IW-1:0];
                                rw_store_data <= issue_cmd[1] ? rs2 :
                                                 issue_cmd[2] ? 32'hFFFF_FFFF : 32'h0;
                                rw_store_mask <= issue_cmd[1] ? 32'hFFFF_FFFF : rs2;
                                result        <= 32'h0;
                            end else begin
                                result <= 32'h1;
                            end
                        end else if (issue_cmd[4]) begin
                            for (int i = 0; i < NINTR; i++) begin
                                isr_pulses[i] <= rs2[0] && (rs1[15:0] == 16'(i));
                            end
                            result <= intr_valid ? 32'h0 : 32'h1;
                        end else begin
                            result <= 32'h0;
                        end
                    end
                end
                StWait: begin
                    // A match on the last permitted compare still counts as success.
                    if (wait_match) begin
                        result  <= 32'(count_q);
                        state_q <= StDone;
                    end else if (32'(count_q) >= TIMEOUT - 1) begin
                        result  <= 32'h8000_0000 | 32'(TIMEOUT - 1);
                        state_q <= StDone;
                    end else if (count_q != {CW{1'b1}}) begin
                        count_q <= count_q + CW'(1);
                    end
                end
                StDone: begin
                    if (wb_ack) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sp_unit_mmr_cmd.sv
// Scoreboard bench for sp_unit_mmr_cmd: the driver pushes expected results, strobes and pulses
// computed from the command rules; independent monitors pop and compare as the DUT presents them.
module tb_sp_unit_mmr_cmd;

    localparam int unsigned NRW        = 8;
    localparam int unsigned NRO        = 8;
    localparam int unsigned NINTR      = 4;
    localparam int unsigned TIMEOUT    = 16;
    localparam int unsigned RO_SEL_BIT = 16;
    localparam int          IW         = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_new_request = 1'b0;
    logic              issue_ready;
    logic [5:0]        issue_cmd = '0;
    logic [31:0]       rs1 = '0;
    logic [31:0]       rs2 = '0;
    logic              wb_done;
    logic              wb_ack = 1'b0;
    logic [31:0]       result;
    logic [NRW*32-1:0] rw_data = '0;
    logic [NRO*32-1:0] ro_data = '0;
    logic              rw_store;
    logic [IW-1:0]     rw_store_idx;
    logic [31:0]       rw_store_data;
    logic [31:0]       rw_store_mask;
    logic [NINTR-1:0]  isr_pulses;

    sp_unit_mmr_cmd #(
        .NRW        (NRW),
        .NRO        (NRO),
        .NINTR      (NINTR),
        .TIMEOUT    (TIMEOUT),
        .RO_SEL_BIT (RO_SEL_BIT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .issue_new_request (issue_new_request),
        .issue_ready       (issue_ready),
        .issue_cmd         (issue_cmd),
        .rs1               (rs1),
        .rs2               (rs2),
        .wb_done           (wb_done),
        .wb_ack            (wb_ack),
        .result            (result),
        .rw_data           (rw_data),
        .ro_data           (ro_data),
        .rw_store          (rw_store),
        .rw_store_idx      (rw_store_idx),
        .rw_store_data     (rw_store_data),
        .rw_store_mask     (rw_store_mask),
        .isr_pulses        (isr_pulses)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] val; } res_t;
    typedef struct { int cyc; logic [IW-1:0] idx; logic [31:0] data; logic [31:0] mask; } st_t;
    typedef struct { int cyc; logic [NINTR-1:0] p; } irq_t;

    res_t res_q[$];
    st_t  st_q[$];
    irq_t irq_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int ack_delay_next = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_pop(input string name, input int size);
        n_checks++;
        if (size == 0) begin
            n_errors++;
            $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
        end
    endfunction

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    function automatic logic [31:0] get_reg(input bit ro, input logic [15:0] idx);
        return ro ? ro_data[32*idx +: 32] : rw_data[32*idx +: 32];
    endfunction

    function automatic void set_reg(input bit ro, input logic [15:0] idx, input logic [31:0] v);
        if (ro) ro_data[32*idx +: 32] = v;
        else    rw_data[32*idx +: 32] = v;
    endfunction

    // Result monitor: one pop per done episode, then the result must hold until it ends.
    bit          mon_prev_done = 1'b0;
    logic [31:0] mon_held = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_done = 1'b0;
                continue;
            end
            if (wb_done && !mon_prev_done) begin
                check_pop("unexpected_done", res_q.size());
                if (res_q.size() != 0) begin
                    res_t e;
                    e = res_q.pop_front();
                    check("result", result, e.val);
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
                mon_held = result;
            end else if (wb_done) begin
                check("result_stable", result, mon_held);
            end
            mon_prev_done = wb_done;
            if (rw_store) begin
                check_pop("unexpected_store", st_q.size());
                if (st_q.size() != 0) begin
                    st_t s;
                    s = st_q.pop_front();
                    check("store_cycle", 32'(cyc), 32'(s.cyc));
                    check("store_idx", 32'(rw_store_idx), 32'(s.idx));
                    check("store_data", rw_store_data, s.data);
                    check("store_mask", rw_store_mask, s.mask);
                end
            end
            if (|isr_pulses) begin
                check_pop("unexpected_pulse", irq_q.size());
                if (irq_q.size() != 0) begin
                    irq_t q;
                    q = irq_q.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(q.cyc));
                    check("pulse_vec", 32'(isr_pulses), 32'(q.p));
                end
            end
        end
    end

    // Ack responder: per-episode delay; also checks done is held until acked and released after.
    bit ack_in_ep = 1'b0;
    int ack_remaining = 0;
    bit ack_prev_done = 1'b0;
    bit ack_prev_ack = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                ack_in_ep = 1'b0;
                wb_ack = 1'b0;
                ack_prev_done = 1'b0;
                ack_prev_ack = 1'b0;
                continue;
            end
            if (ack_prev_done && ack_prev_ack) begin
                check("done_clear_after_ack", 32'(wb_done), 32'd0);
                check("ready_after_ack", 32'(issue_ready), 32'd1);
            end else if (ack_prev_done) begin
                check("done_held", 32'(wb_done), 32'd1);
            end
            ack_prev_done = wb_done;
            if (wb_done) begin
                if (!ack_in_ep) begin
                    ack_in_ep = 1'b1;
                    ack_remaining = ack_delay_next;
                    ack_delay_next = $urandom_range(0, 2);
                end
                if (ack_remaining == 0) begin
                    wb_ack = 1'b1;
                end else begin
                    wb_ack = 1'b0;
                    ack_remaining--;
                end
            end else begin
                ack_in_ep = 1'b0;
                wb_ack = ($urandom_range(0, 3) == 0);
            end
            ack_prev_ack = wb_ack;
        end
    end

    // Returns at a negedge with the unit idle; busy cycles carry a request that must be ignored.
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!issue_ready) begin
            if (n > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL ready_timeout: got issue_ready 0, expected 1 within 200 cycles");
                finish_sim();
            end
            issue_new_request = 1'b1;
            issue_cmd = 6'b000010;
            rs1 = 32'($urandom_range(0, NRW - 1));
            rs2 = $urandom;
            @(negedge clk);
            n++;
        end
    endtask

    // Issues one command at an idle negedge; k is the compare at which WAIT's bits get set.
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                         input int k, input bit push);
        logic [15:0] idx;
        bit          ro;
        bit          valid;
        int          base;
        int          n;
        logic [31:0] v;
        idx   = a[15:0];
        ro    = a[RO_SEL_BIT];
        valid = ro ? (32'(idx) < NRO) : (32'(idx) < NRW);
        if (op == 5 && valid && b != 0) begin
            v = $urandom & ~(b & (~b + 32'd1));
            set_reg(ro, idx, v);
        end
        issue_new_request = 1'b1;
        issue_cmd = 6'(1 << op);
        rs1 = a;
        rs2 = b;
        @(posedge clk);
        #1;
        base = cyc;
        issue_new_request = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        issue_cmd = 6'(1 << $urandom_range(0, 5));
        case (op)
            0: if (push) res_q.push_back('{cyc: base, val: valid ? get_reg(ro, idx) : 32'h0});
            1, 2, 3: begin
                if (push) begin
                    if (valid && !ro) begin
                        st_q.push_back('{cyc: base, idx: idx[IW-1:0],
                                         data: (op == 1) ? b : (op == 2) ? 32'hFFFF_FFFF : 32'h0,
                                         mask: (op == 1) ? 32'hFFFF_FFFF : b});
                        res_q.push_back('{cyc: base, val: 32'h0});
                    end else begin
                        res_q.push_back('{cyc: base, val: 32'h1});
                    end
                end
            end
            4: begin
                if (push) begin
                    if (32'(idx) < NINTR) begin
                        irq_t q;
                        q.cyc = base;
                        q.p = '0;
                        q.p[idx] = 1'b1;
                        if (b[0]) irq_q.push_back(q);
                        res_q.push_back('{cyc: base, val: 32'h0});
                    end else begin
                        res_q.push_back('{cyc: base, val: 32'h1});
                    end
                end
            end
            default: begin
                if (!valid) begin
                    if (push) res_q.push_back('{cyc: base, val: 32'h8000_0000});
                end else begin
                    n = (b == 0) ? 0 : k;
                    if (push) begin
                        if (n < int'(TIMEOUT)) res_q.push_back('{cyc: base + n + 1, val: 32'(n)});
                        else res_q.push_back('{cyc: base + int'(TIMEOUT),
                                               val: 32'h8000_0000 | 32'(TIMEOUT - 1)});
                    end
                    if (b != 0 && k < int'(TIMEOUT)) begin
                        if (k > 0) begin
                            repeat (k) @(posedge clk);
                            #1;
                        end
                        set_reg(ro, idx, get_reg(ro, idx) | b);
                    end
                end
            end
        endcase
    endtask

    initial begin
        #900000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got no end of run, expected finish before 900000ns");
        finish_sim();
    end

    initial begin
        for (int i = 0; i < int'(NRW); i++) rw_data[32*i +: 32] = $urandom;
        for (int i = 0; i < int'(NRO); i++) ro_data[32*i +: 32] = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_wb_done", 32'(wb_done), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_rw_store", 32'(rw_store), 32'd0);
        check("rst_store_idx", 32'(rw_store_idx), 32'd0);
        check("rst_store_data", rw_store_data, 32'h0);
        check("rst_store_mask", rw_store_mask, 32'h0);
        check("rst_isr", 32'(isr_pulses), 32'd0);
        rst = 1'b0;

        // Directed cases.
        wait_ready();
        set_reg(1'b0, 16'd2, 32'hDEAD_BEEF);
        ack_delay_next = 3;
        issue(0, 32'd2, $urandom, 0, 1'b1);
        wait_ready();
        issue(1, 32'd5, 32'h1234_5678, 0, 1'b1);
        wait_ready();
        issue(2, 32'd1, 32'h0000_00F0, 0, 1'b1);
        wait_ready();
        issue(3, 32'h0001_0001, $urandom, 0, 1'b1);
        wait_ready();
        issue(4, 32'd3, 32'd1, 0, 1'b1);
        wait_ready();
        issue(4, 32'd7, 32'd1, 0, 1'b1);
        wait_ready();
        issue(5, 32'd0, 32'h80, 5, 1'b1);
        wait_ready();
        issue(5, 32'd0, 32'h80, 1000, 1'b1);
        wait_ready();
        issue(5, 32'd4, 32'h0, 0, 1'b1);
        wait_ready();
        issue(5, 32'd9, 32'h1, 0, 1'b1);

        // Reset while polling: nothing may complete, and the unit is idle right after.
        wait_ready();
        issue(5, 32'd0, 32'h1, 1000, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midwait_rst_done", 32'(wb_done), 32'd0);
        check("midwait_rst_ready", 32'(issue_ready), 32'd1);
        check("midwait_rst_result", result, 32'h0);
        check("midwait_rst_store", 32'(rw_store), 32'd0);
        check("midwait_rst_isr", 32'(isr_pulses), 32'd0);
        wait_ready();
        set_reg(1'b1, 16'd3, 32'hCAFE_F00D);
        issue(0, 32'h0001_0003, $urandom, 0, 1'b1);

        // Randomized commands.
        for (int it = 0; it < 300; it++) begin
            int          op;
            logic [31:0] a;
            logic [31:0] b;
            logic [15:0] idx;
            wait_ready();
            for (int i = 0; i < int'(NRW); i++) rw_data[32*i +: 32] = $urandom;
            for (int i = 0; i < int'(NRO); i++) ro_data[32*i +: 32] = $urandom;
            op  = $urandom_range(0, 5);
            idx = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
            a = $urandom;
            a[15:0] = idx;
            a[RO_SEL_BIT] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) b = 32'h0;
            else if (op == 5)              b = $urandom & $urandom & $urandom;
            else                           b = $urandom;
            issue(op, a, b, $urandom_range(0, TIMEOUT + 3), 1'b1);
        end

        begin
            int n;
            n = 0;
            while ((res_q.size() != 0 || !issue_ready) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("res_queue_drained", 32'(res_q.size()), 32'd0);
        check("store_queue_drained", 32'(st_q.size()), 32'd0);
        check("pulse_queue_drained", 32'(irq_q.size()), 32'd0);
        finish_sim();
    end

endmodule
